// File: rtl/avoid_ctrl.sv
// rtl/avoid_ctrl.sv - obstacle-avoidance motion FSM with timed dwell states
//
// Purpose: drives forward, reverse and turn commands from the debounced
// front, left and right barrier levels. A barrier ahead causes a settle
// pause and then a one-cycle decision:
//   - go forward again if the front is clear,
//   - otherwise turn left, turn right, or reverse and then turn right.
// Every turn returns to settle so that the front can be re-evaluated.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - run enable; low forces IDLE
//   front_bar  - front barrier present (level)
//   left_bar   - left barrier present (level)
//   right_bar  - right barrier present (level)
//   fwd        - drive-forward command
//   back       - drive-reverse command
//   left       - turn-left command
//   right      - turn-right command
//   state      - current FSM state code (debug)
//   avoid_cnt  - number of blocked decisions, wraps at 256
module avoid_ctrl #(
    parameter int unsigned SETTLE_CYC = 50,
    parameter int unsigned TURN_CYC   = 1000,
    parameter int unsigned BACK_CYC   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       front_bar,
    input  logic       left_bar,
    input  logic       right_bar,
    output logic       fwd,
    output logic       back,
    output logic       left,
    output logic       right,
    output logic [2:0] state,
    output logic [7:0] avoid_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FWD     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_TURN_L  = 3'd4,
        ST_TURN_R  = 3'd5,
        ST_REVERSE = 3'd6,
        ST_UNUSED  = 3'd7
    } state_t;

    // Last dwell count of each timed state; the exit happens on the edge
    // that ends the cycle in which the counter shows this value.
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TURN_LAST   = 16'(TURN_CYC - 1);
    localparam logic [15:0] BACK_LAST   = 16'(BACK_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] dwell_q, dwell_d;
    logic [7:0]  avoid_q, avoid_d;
    logic        fwd_q, fwd_d;
    logic        back_q, back_d;
    logic        left_q, left_d;
    logic        right_q, right_d;

    always_comb begin
        state_d = state_q;
        // Zero unless a timed state keeps counting, so every entry starts at 0.
        dwell_d = 16'd0;
        avoid_d = avoid_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FWD;
            end
            ST_FWD: begin
                if (front_bar) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (dwell_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            ST_DECIDE: begin
                if (!front_bar) begin
                    state_d = ST_FWD;
                end else begin
                    avoid_d = avoid_q + 8'd1;
                    if (!left_bar) begin
                        state_d = ST_TURN_L;
                    end else if (!right_bar) begin
                        state_d = ST_TURN_R;
                    end else begin
                        state_d = ST_REVERSE;
                    end
                end
            end
            ST_TURN_L, ST_TURN_R: begin
                if (dwell_q == TURN_LAST) begin
                    state_d = ST_SETTLE;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            ST_REVERSE: begin
                // Backing away always leaves the robot facing the same wall,
                // so it turns right before re-evaluating.
                if (dwell_q == BACK_LAST) begin
                    state_d = ST_TURN_R;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping the run enable wins over every transition above.
        if (!start) begin
            state_d = ST_IDLE;
            dwell_d = 16'd0;
        end

        // Outputs are decoded from the next state so the registered copies
        // always match the state register exactly.
        fwd_d   = (state_d == ST_FWD);
        back_d  = (state_d == ST_REVERSE);
        left_d  = (state_d == ST_TURN_L);
        right_d = (state_d == ST_TURN_R);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dwell_q <= 16'd0;
            avoid_q <= 8'd0;
            fwd_q   <= 1'b0;
            back_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            avoid_q <= avoid_d;
            fwd_q   <= fwd_d;
            back_q  <= back_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign fwd       = fwd_q;
    assign back      = back_q;
    assign left      = left_q;
    assign right     = right_q;
    assign state     = state_q;
    assign avoid_cnt = avoid_q;

endmodule

// File: tb/tb_avoid_ctrl.sv
// tb/tb_avoid_ctrl.sv - self-checking bench for avoid_ctrl
module tb_avoid_ctrl;

    localparam int SETTLE = 4;
    localparam int TURN   = 8;
    localparam int BACK   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       front_bar = 1'b0;
    logic       left_bar = 1'b0;
    logic       right_bar = 1'b0;
    logic       fwd, back, left, right;
    logic [2:0] state;
    logic [7:0] avoid_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: state number, cycles still to spend in a timed state, counter.
    int m_state = 0;
    int m_rem = 0;
    int m_avoid = 0;

    avoid_ctrl #(
        .SETTLE_CYC(SETTLE),
        .TURN_CYC  (TURN),
        .BACK_CYC  (BACK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .front_bar(front_bar),
        .left_bar (left_bar),
        .right_bar(right_bar),
        .fwd      (fwd),
        .back     (back),
        .left     (left),
        .right    (right),
        .state    (state),
        .avoid_cnt(avoid_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dwell_of(input int s);
        case (s)
            2:       return SETTLE;
            4, 5:    return TURN;
            6:       return BACK;
            default: return 0;
        endcase
    endfunction

    function automatic int after_timed(input int s);
        case (s)
            2:       return 3;
            6:       return 5;
            default: return 2;
        endcase
    endfunction

    task go(input int s);
        m_state = s;
        m_rem   = dwell_of(s);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_rem   = 0;
            m_avoid = 0;
        end else if (!start) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: go(1);
                1: if (front_bar) go(2);
                2, 4, 5, 6: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) go(after_timed(m_state));
                end
                3: begin
                    if (!front_bar) go(1);
                    else begin
                        m_avoid = (m_avoid + 1) % 256;
                        if (!left_bar)       go(4);
                        else if (!right_bar) go(5);
                        else                 go(6);
                    end
                end
                default: go(0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("fwd", int'(fwd), int'(m_state == 1));
            chk("left", int'(left), int'(m_state == 4));
            chk("right", int'(right), int'(m_state == 5));
            chk("back", int'(back), int'(m_state == 6));
            chk("avoid_cnt", int'(avoid_cnt), m_avoid);
            chk("onehot", int'($countones({fwd, back, left, right}) <= 1), 1);
        end
    end

    // Counts consecutive sampled cycles spent in a state, starting with the
    // current sample; returns on the first sample of the following state.
    task automatic measure(input int code, input int exp_len, input string name);
        int n = 0;
        while (int'(state) == code && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp_len);
    endtask

    initial begin
        int nd;
        int cyc;

        // Reset, then run enable with no barriers.
        @(negedge clk);
        chk_en = 1'b1;
        chk("a_reset_state1", int'(state), 0);
        @(negedge clk);
        chk("a_reset_state2", int'(state), 0);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("a_fwd_state", int'(state), 1);
        chk("a_fwd_out", int'(fwd), 1);
        repeat (5) @(negedge clk);
        chk("a_fwd_held", int'(state), 1);

        // Front blocked, left free: turn left.
        front_bar = 1'b1; left_bar = 1'b0; right_bar = 1'b0;
        @(negedge clk);
        measure(2, SETTLE, "b_settle1");
        measure(3, 1, "b_decide1");
        chk("b_left_on", int'(left), 1);
        measure(4, TURN, "b_turn_l");
        measure(2, SETTLE, "b_settle2");
        chk("b_decide2", int'(state), 3);
        chk("b_avoid", int'(avoid_cnt), 1);
        front_bar = 1'b0;
        @(negedge clk);
        chk("b_fwd_again", int'(state), 1);
        chk("b_avoid_hold", int'(avoid_cnt), 1);

        // Front and left blocked: turn right.
        front_bar = 1'b1; left_bar = 1'b1; right_bar = 1'b0;
        @(negedge clk);
        measure(2, SETTLE, "c_settle1");
        measure(3, 1, "c_decide1");
        measure(5, TURN, "c_turn_r");
        front_bar = 1'b0;
        measure(2, SETTLE, "c_settle2");
        chk("c_decide2", int'(state), 3);
        @(negedge clk);
        chk("c_fwd_again", int'(state), 1);
        chk("c_avoid", int'(avoid_cnt), 2);

        // Fully boxed in: reverse, then turn right.
        front_bar = 1'b1; left_bar = 1'b1; right_bar = 1'b1;
        @(negedge clk);
        measure(2, SETTLE, "d_settle1");
        measure(3, 1, "d_decide1");
        measure(6, BACK, "d_reverse");
        measure(5, TURN, "d_turn_r");
        measure(2, SETTLE, "d_settle2");
        chk("d_decide2", int'(state), 3);
        front_bar = 1'b0;
        @(negedge clk);
        chk("d_fwd_again", int'(state), 1);
        chk("d_avoid", int'(avoid_cnt), 3);

        // Run enable dropped in the third cycle of a left turn.
        front_bar = 1'b1; left_bar = 1'b0; right_bar = 1'b0;
        @(negedge clk);
        measure(2, SETTLE, "e_settle1");
        measure(3, 1, "e_decide1");
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("e_idle", int'(state), 0);
        chk("e_left_off", int'(left), 0);
        chk("e_avoid_hold", int'(avoid_cnt), 4);
        start = 1'b1;
        front_bar = 1'b0;
        @(negedge clk);
        chk("e_refwd", int'(state), 1);
        front_bar = 1'b1;
        @(negedge clk);
        measure(2, SETTLE, "e_settle2");
        measure(3, 1, "e_decide2");
        measure(4, TURN, "e_turn_l_full");

        // Reset overrides start; then 260 blocked decisions wrap the counter.
        rst_n = 1'b0;
        front_bar = 1'b1; left_bar = 1'b1; right_bar = 1'b1;
        @(negedge clk);
        chk("f_reset_state", int'(state), 0);
        chk("f_reset_avoid", int'(avoid_cnt), 0);
        rst_n = 1'b1;
        nd = 0;
        cyc = 0;
        while (nd < 260 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (state == 3'd3) nd++;
        end
        chk("f_decides", nd, 260);
        @(negedge clk);
        chk("f_avoid_wrap", int'(avoid_cnt), 4);

        // Reset in the middle of reversing aborts immediately.
        chk("g_in_reverse", int'(state), 6);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("g_reset_state", int'(state), 0);
        chk("g_back_off", int'(back), 0);
        chk("g_avoid_clear", int'(avoid_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avoid_ctrl.md
AVOID_CTRL -- requirements
Module: avoid_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 50: dwell cycles in SETTLE; legal range 1..65535.
REQ-002 Parameter TURN_CYC, default 1000: dwell cycles in TURN_L and TURN_R; legal range 1..65535.
REQ-003 Parameter BACK_CYC, default 500: dwell cycles in REVERSE; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  run enable; 0 forces IDLE.
REQ-007 front_bar  input  1  debounced front barrier present, level.
REQ-008 left_bar  input  1  debounced left barrier present, level.
REQ-009 right_bar  input  1  debounced right barrier present, level.
REQ-010 fwd  output  1  drive-forward command.
REQ-011 back  output  1  drive-reverse command.
REQ-012 left  output  1  turn-left command.
REQ-013 right  output  1  turn-right command.
REQ-014 state  output  3  current FSM state code, debug.
REQ-015 avoid_cnt  output  8  count of blocked DECIDE evaluations, wraps.

Function
REQ-016 FSM states and codes SHALL be IDLE=0, FWD=1, SETTLE=2, DECIDE=3, TURN_L=4, TURN_R=5, REVERSE=6; code 7 unused, SHALL go to IDLE next cycle.
REQ-017 Outputs SHALL be Moore-decoded from the state register: fwd only in FWD, left only in TURN_L, right only in TURN_R, back only in REVERSE; all zero otherwise; at most one asserted in any cycle.
REQ-018 IDLE: start=1 at an edge SHALL enter FWD at that edge; fwd=1 in the following cycle.
REQ-019 FWD: front_bar=1 at an edge SHALL enter SETTLE; otherwise remain.
REQ-020 A 16-bit dwell counter SHALL clear to 0 on every state entry and increment each cycle while in SETTLE, TURN_L, TURN_R, REVERSE.
REQ-021 Exit of a timed state SHALL occur at the edge where counter equals its parameter minus 1, giving dwell of exactly SETTLE_CYC, TURN_CYC or BACK_CYC cycles.
REQ-022 SETTLE exits to DECIDE; TURN_L and TURN_R exit to SETTLE; REVERSE exits to TURN_R.
REQ-023 DECIDE SHALL last exactly 1 cycle, with priority: front_bar=0 -> FWD; else left_bar=0 -> TURN_L; else right_bar=0 -> TURN_R; else REVERSE.
REQ-024 avoid_cnt SHALL increment by 1 on each DECIDE cycle with front_bar=1, wrapping 255 -> 0.
REQ-025 start=0 at any edge in any state SHALL force IDLE and clear dwell counter; avoid_cnt SHALL hold.
REQ-026 Barrier inputs SHALL be ignored in all states except FWD and DECIDE.

Reset
REQ-027 rst_n=0 at an edge SHALL set state=IDLE, dwell counter=0, avoid_cnt=0, all motion outputs 0; reset overrides start.
REQ-028 Reset asserted mid-turn or mid-reverse SHALL abort at that edge; no motion output persists past that edge.

Verification (SETTLE_CYC=4, TURN_CYC=8, BACK_CYC=6)
REQ-029 rst_n=0 2 cycles, then start=1, no barriers -> state 0 during reset, state 1 and fwd=1 one cycle after first start edge, held indefinitely.
REQ-030 In FWD, front_bar=1, left_bar=0 held -> SETTLE 4 cycles (all outputs 0), DECIDE 1 cycle, left=1 exactly 8 cycles, SETTLE 4, DECIDE; avoid_cnt increments once per DECIDE.
REQ-031 front_bar=left_bar=1, right_bar=0 -> after SETTLE/DECIDE, right=1 exactly 8 cycles.
REQ-032 All three barriers=1 -> back=1 exactly 6 cycles, then right=1 8 cycles, then SETTLE 4, DECIDE.
REQ-033 start dropped to 0 on 3rd cycle of TURN_L -> next cycle state=0, left=0; start=1 again -> FWD with counter restarted; avoid_cnt unchanged.
REQ-034 260 consecutive blocked DECIDE cycles -> avoid_cnt=4 (wrap); one-hot check on fwd/back/left/right every cycle of all scenarios.
